// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: load-use/branch/dmem stall sequencing and registered forwarding selects; STALL_PERF_COUNT_EN builds the stall_cycles counter
module pipeline_stall_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  mem_rd_addr,
  input  logic        mem_reg_write,
  input  logic        branch_taken_ex,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        ex_mem_stall,
  output logic        mem_wb_stall,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles
);
  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;
  localparam logic [1:0]  FRELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TO_MAX  = 16'(MEM_TIMEOUT);
  state_t      state_q, state_d, ret_q, eff;
  logic [1:0]  fcnt_q, fcnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        mem_timeout_q;
  logic [1:0]  fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic        mem_wait, load_use, flush, lu_stall, bubble;
  always_comb begin
    mem_wait = dmem_req && !dmem_ready;
    eff      = (state_q == MEM_WAIT) ? ret_q : state_q;
    load_use = ex_mem_read && ex_reg_write && ex_rd_addr != 5'd0 &&
               ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
    flush    = !mem_wait && (eff == FLUSH || branch_taken_ex);
    lu_stall = !mem_wait && eff == RUN && !branch_taken_ex && load_use;
    bubble   = flush || lu_stall;
    fcnt_d   = mem_wait ? fcnt_q : !flush ? 2'd0 : branch_taken_ex ? FRELOAD : fcnt_q - 2'd1;
    state_d  = mem_wait ? MEM_WAIT : (fcnt_d != 2'd0) ? FLUSH : RUN;
    to_cnt_d = !mem_wait ? 16'd0 : (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 16'd1;
    fwd_a_d  = (ex_reg_write && ex_rd_addr != 5'd0 && ex_rd_addr == id_rs1_addr) ? 2'b01 :
               (mem_reg_write && mem_rd_addr != 5'd0 && mem_rd_addr == id_rs1_addr) ? 2'b10 : 2'b00;
    fwd_b_d  = (ex_reg_write && ex_rd_addr != 5'd0 && ex_rd_addr == id_rs2_addr) ? 2'b01 :
               (mem_reg_write && mem_rd_addr != 5'd0 && mem_rd_addr == id_rs2_addr) ? 2'b10 : 2'b00;
  end
  // reset forces every hazard output low even while it is asserted
  assign pc_stall     = !reset && (mem_wait || lu_stall);
  assign if_id_stall  = !reset && (mem_wait || lu_stall);
  assign ex_mem_stall = !reset && mem_wait;
  assign mem_wb_stall = !reset && mem_wait;
  assign id_ex_bubble = !reset && bubble;
  assign if_id_flush  = !reset && flush;
  assign fwd_a_sel    = fwd_a_q;
  assign fwd_b_sel    = fwd_b_q;
  assign mem_timeout  = mem_timeout_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      ret_q         <= RUN;
      fcnt_q        <= 2'd0;
      to_cnt_q      <= 16'd0;
      mem_timeout_q <= 1'b0;
      fwd_a_q       <= 2'b00;
      fwd_b_q       <= 2'b00;
    end else begin
      state_q       <= state_d;
      ret_q         <= eff;
      fcnt_q        <= fcnt_d;
      to_cnt_q      <= to_cnt_d;
      mem_timeout_q <= mem_timeout_q || to_cnt_d == TO_MAX;
      fwd_a_q       <= mem_wait ? fwd_a_q : bubble ? 2'b00 : fwd_a_d;
      fwd_b_q       <= mem_wait ? fwd_b_q : bubble ? 2'b00 : fwd_b_d;
    end
  end
`ifdef STALL_PERF_COUNT_EN
  logic [15:0] perf_q;
  always_ff @(posedge clk) begin
    if (reset) perf_q <= 16'd0;
    else if ((pc_stall || if_id_flush) && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
  end
  assign stall_cycles = perf_q;
`else
  assign stall_cycles = 16'd0;
`endif
endmodule
